// File: rtl/obi_sbr_regfile.sv
// OBI subordinate: byte-addressable register file behind an in-order response FIFO.
// Out-of-range accesses return an error response and bump a saturating error counter.
module obi_sbr_regfile #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_WORDS  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RSP_DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  input  logic                    obi_rready_i,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BE_W);
  localparam int unsigned IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q       [NUM_WORDS];
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic                  fifo_err_q  [RSP_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  gnt_q, gnt_d;

  logic                  accept;
  logic                  pop;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_err;

  // Grant comes from registered occupancy only; held low while in reset.
  assign obi_gnt_o    = reset_ni & gnt_q;
  assign obi_rvalid_o = (count_q != '0);
  assign obi_rdata_o  = obi_rvalid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign obi_err_o    = obi_rvalid_o ? fifo_err_q[rd_ptr_q] : 1'b0;
  assign err_cnt_o    = err_cnt_q;

  assign accept = obi_req_i & obi_gnt_o;
  assign pop    = obi_rvalid_o & obi_rready_i;

  // Address decode: word index relative to the base, full-width range check with no wrap.
  always_comb begin
    off      = obi_addr_i - BASE_ADDR;
    idx      = off[OFF_BITS +: IDX_W];
    in_range = (obi_addr_i >= BASE_ADDR) && ((off >> OFF_BITS) < ADDR_WIDTH'(NUM_WORDS));
  end

  // Next-state for FIFO pointers, occupancy, grant and error counter; response payload.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    push_data = '0;
    push_err  = 1'b0;

    if (accept) begin
      if (!in_range) begin
        push_err = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (!obi_we_i) begin
        push_data = mem_q[idx];
      end
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    gnt_d = (count_d < CNT_W'(RSP_DEPTH));
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      gnt_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      gnt_q     <= gnt_d;
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else if (accept) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= push_err;
    end
  end

  // Register file with per-byte write enables.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (accept && in_range && obi_we_i) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (obi_be_i[k]) mem_q[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_obi_sbr_regfile.sv
// Bench for obi_sbr_regfile: directed and random OBI traffic, scoreboard of expected responses.
module tb_obi_sbr_regfile;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 16;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic        obi_rready_i;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic [7:0]  err_cnt_o;

  obi_sbr_regfile #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW), .BASE_ADDR(BASE), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
    .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mdl_mem [NW];
  logic [32:0] exp_q [$];   // {err, rdata}
  int          mdl_cnt = 0;
  int          mdl_err = 0;
  int          rr_mode = 1; // 0: hold low, 1: always ready, 2: random

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: applies each accepted request at the clock edge using pre-edge state.
  always @(posedge clk) begin
    logic acc, pp, inr;
    logic [31:0] a, rd;
    int w;
    if (!reset_ni) begin
      for (int i = 0; i < NW; i++) mdl_mem[i] = '0;
      exp_q.delete();
      mdl_cnt = 0;
      mdl_err = 0;
    end else begin
      acc = obi_req_i && obi_gnt_o;
      pp  = obi_rvalid_o && obi_rready_i;
      if (acc) begin
        a   = obi_addr_i;
        inr = (a >= BASE) && (((a - BASE) / 4) < NW);
        if (!inr) begin
          exp_q.push_back({1'b1, 32'h0});
          if (mdl_err < 255) mdl_err++;
        end else begin
          w = int'((a - BASE) / 4);
          rd = mdl_mem[w];
          if (obi_we_i) begin
            for (int k = 0; k < 4; k++)
              if (obi_be_i[k]) mdl_mem[w][8*k +: 8] = obi_wdata_i[8*k +: 8];
            exp_q.push_back({1'b0, 32'h0});
          end else begin
            exp_q.push_back({1'b0, rd});
          end
        end
      end
      mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (pp ? 1 : 0);
    end
  end

  // Monitor: compares handshake state and the presented response every cycle.
  always @(negedge clk) begin
    logic [32:0] e;
    chk("gnt", 64'(obi_gnt_o), 64'(reset_ni && (mdl_cnt < DEPTH)));
    chk("rvalid", 64'(obi_rvalid_o), 64'(mdl_cnt != 0));
    chk("err_cnt", 64'(err_cnt_o), 64'(mdl_err));
    if (obi_rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q[0];
        chk("rdata", 64'(obi_rdata_o), 64'(e[31:0]));
        chk("err", 64'(obi_err_o), 64'(e[32]));
        if (obi_rready_i) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_rsp", 64'({obi_err_o, obi_rdata_o}), 64'(0));
    end
  end

  // Ready generator.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       obi_rready_i = 1'b0;
      1:       obi_rready_i = 1'b1;
      default: obi_rready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    int n = 0;
    obi_req_i = 1'b1; obi_addr_i = a; obi_we_i = we; obi_be_i = be; obi_wdata_i = wd;
    forever begin
      @(negedge clk);
      if (obi_gnt_o) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL gnt_timeout: no grant after %0d cycles, expected grant", n);
        break;
      end
    end
    @(posedge clk); #1;
    obi_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    obi_req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    reset_ni = 1'b0; obi_req_i = 1'b0; obi_addr_i = '0; obi_we_i = 1'b0;
    obi_be_i = '0; obi_wdata_i = '0; obi_rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;
    idle(2);

    // Full write then read back.
    do_req(BASE + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF);
    do_req(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
    idle(3);

    // Partial byte-enable write over an existing word.
    do_req(BASE + 32'h8, 1'b1, 4'hF, 32'hAABB_CCDD);
    do_req(BASE + 32'h8, 1'b1, 4'b0101, 32'h1122_3344);
    do_req(BASE + 32'h8, 1'b0, 4'hF, 32'h0);
    idle(3);

    // Backpressure: third read stalls until a response is popped.
    rr_mode = 0;
    idle(2);
    fork
      begin
        do_req(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
        do_req(BASE + 32'h8, 1'b0, 4'h0, 32'h0);
        do_req(BASE + 32'h0, 1'b0, 4'h0, 32'h0);
      end
      begin
        repeat (8) @(negedge clk);
        rr_mode = 1;
      end
    join
    idle(4);

    // Out-of-range above and below the window, including writes that must not land.
    do_req(BASE + 32'(NW * 4), 1'b0, 4'h0, 32'h0);
    do_req(BASE - 32'h4, 1'b0, 4'h0, 32'h0);
    do_req(BASE - 32'h4, 1'b1, 4'hF, 32'h5555_5555);
    do_req(BASE + 32'(NW * 4), 1'b1, 4'hF, 32'h6666_6666);
    do_req(BASE + 32'h3C, 1'b0, 4'h0, 32'h0);
    idle(3);

    // Back-to-back traffic with the manager always ready.
    for (int i = 0; i < 16; i++) do_req(BASE + 32'(4 * i), 1'b1, 4'hF, $urandom);
    for (int i = 0; i < 16; i++) do_req(BASE + 32'(4 * i) + 32'($urandom_range(0, 3)), 1'b0, 4'h0, 32'h0);
    idle(3);

    // Reset with responses still queued.
    rr_mode = 0;
    idle(2);
    do_req(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
    do_req(BASE + 32'h8, 1'b0, 4'h0, 32'h0);
    reset_ni = 1'b0;
    @(posedge clk); #1;
    chk("rvalid_after_reset", 64'(obi_rvalid_o), 64'(0));
    chk("gnt_in_reset", 64'(obi_gnt_o), 64'(0));
    reset_ni = 1'b1;
    rr_mode = 1;
    @(posedge clk); #1;
    do_req(BASE + 32'h4, 1'b0, 4'h0, 32'h0);
    do_req(BASE + 32'h8, 1'b0, 4'h0, 32'h0);
    idle(3);

    // Random mix against the model with random backpressure.
    rr_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      else a = BASE + 32'($urandom_range(0, NW * 4 + 15));
      do_req(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rr_mode = 1;
    idle(4);

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++) do_req(BASE + 32'(NW * 4) + 32'(4 * (i % 8)), 1'b0, 4'h0, 32'h0);
    idle(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
